// File: rtl/seq_elastic_pipe_reg_pkg.sv
// Shared types and helpers for the elastic register pipeline.
// Occupancy width and the per-stage control bundle live here so the interface and RTL agree.
package seq_pipe_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic valid;
    logic ready;
  } stage_ctl_t;

endpackage

// File: rtl/seq_elastic_pipe_reg_if.sv
// Valid/ready handshake bundle for the elastic pipeline: upstream push side,
// downstream pop side and occupancy readout.
interface seq_elastic_pipe_reg_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  logic                                     in_valid;
  logic                                     in_ready;
  logic [WIDTH-1:0]                         in_data;
  logic                                     out_valid;
  logic                                     out_ready;
  logic [WIDTH-1:0]                         out_data;
  logic [seq_pipe_pkg::cnt_w(DEPTH)-1:0]    occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/seq_elastic_pipe_reg_stage.sv
// One elastic register stage: holds a beat until the next stage can take it,
// and accepts a new one whenever it is empty or being drained.
module seq_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    ready_o = !valid_q || ready_i;
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      // data only moves with a real beat; idle cycles keep the old value
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/seq_elastic_pipe_reg.sv
// DEPTH-stage elastic register pipeline with backpressure, flush and a
// registered occupancy count of valid stages.
module seq_elastic_pipe_reg
  import seq_pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  seq_elastic_pipe_reg_if.slave bus
);
  localparam int CW = cnt_w(DEPTH);

  logic          in_fire, out_fire;
  logic [CW-1:0] occ_q, occ_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    logic             v_in, r_in;
    logic [WIDTH-1:0] d_in, d_out;
    stage_ctl_t       ctl;

    if (i == 0) begin : g_src
      assign v_in = bus.in_valid;
      assign d_in = bus.in_data;
    end else begin : g_src
      assign v_in = g_stg[i-1].ctl.valid;
      assign d_in = g_stg[i-1].d_out;
    end

    // ready ripples back from the output through per-stage signals
    if (i == DEPTH - 1) begin : g_snk
      assign r_in = bus.out_ready;
    end else begin : g_snk
      assign r_in = g_stg[i+1].ctl.ready;
    end

    seq_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .valid_i (v_in),
      .data_i  (d_in),
      .ready_o (ctl.ready),
      .valid_o (ctl.valid),
      .data_o  (d_out),
      .ready_i (r_in)
    );
  end

  assign bus.in_ready  = g_stg[0].ctl.ready;
  assign bus.out_valid = g_stg[DEPTH-1].ctl.valid;
  assign bus.out_data  = g_stg[DEPTH-1].d_out;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_comb begin
    occ_d = occ_q;
    if (in_fire && !out_fire) begin
      occ_d = occ_q + 1'b1;
    end else if (out_fire && !in_fire) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_seq_elastic_pipe_reg.sv
// Bench for the elastic pipeline: directed DEPTH=3 steps, then random traffic
// on DEPTH=1 and DEPTH=5 against a slot-position reference model.
module tb_seq_elastic_pipe_reg;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  seq_elastic_pipe_reg_if #(.WIDTH(8),  .DEPTH(3)) if3 ();
  seq_elastic_pipe_reg_if #(.WIDTH(16), .DEPTH(1)) if1 ();
  seq_elastic_pipe_reg_if #(.WIDTH(16), .DEPTH(5)) if5 ();

  seq_elastic_pipe_reg #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .bus(if3));
  seq_elastic_pipe_reg #(.WIDTH(16), .DEPTH(1), .RESET_VAL(16'h0000)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .bus(if1));
  seq_elastic_pipe_reg #(.WIDTH(16), .DEPTH(5), .RESET_VAL(16'h0000)) u_d5 (
    .clk(clk), .rst(rst), .flush(flush), .bus(if5));

  // Reference: ordered list of beats in flight, each with the slot it occupies.
  // A beat moves one slot per cycle toward the output unless the slot ahead is taken.
  logic [15:0] m_data [2][8];
  int          m_pos  [2][8];
  int          m_cnt  [2];
  bit          r_iv   [2];
  bit          r_or   [2];
  bit          r_fin  [2];
  bit          r_fout [2];
  logic [15:0] r_d    [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_check(input int k, input int d, input logic rdy, input logic vld,
                           input logic [15:0] dat, input logic [31:0] occ);
    bit exp_rdy, exp_vld;
    exp_rdy = (m_cnt[k] < d) || r_or[k];
    exp_vld = (m_cnt[k] > 0) && (m_pos[k][0] == d - 1);
    chk($sformatf("rnd_d%0d in_ready", d),  32'(rdy), 32'(exp_rdy));
    chk($sformatf("rnd_d%0d out_valid", d), 32'(vld), 32'(exp_vld));
    chk($sformatf("rnd_d%0d occupancy", d), occ, 32'(m_cnt[k]));
    if (exp_vld) chk($sformatf("rnd_d%0d out_data", d), 32'(dat), 32'(m_data[k][0]));
    r_fin[k]  = r_iv[k] && exp_rdy;
    r_fout[k] = exp_vld && r_or[k];
  endtask

  task automatic model_step(input int k, input int d);
    int lim;
    int nxt;
    if (r_fout[k]) begin
      for (int j = 0; j < m_cnt[k] - 1; j++) begin
        m_data[k][j] = m_data[k][j+1];
        m_pos[k][j]  = m_pos[k][j+1];
      end
      m_cnt[k]--;
    end
    for (int j = 0; j < m_cnt[k]; j++) begin
      lim = (j == 0) ? d - 1 : m_pos[k][j-1] - 1;
      nxt = m_pos[k][j] + 1;
      m_pos[k][j] = (nxt > lim) ? lim : nxt;
    end
    if (r_fin[k]) begin
      m_data[k][m_cnt[k]] = r_d[k];
      m_pos[k][m_cnt[k]]  = 0;
      m_cnt[k]++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    if3.in_valid = 1'b1; if3.in_data = 8'hAA; if3.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = '0;    if1.out_ready = 1'b0;
    if5.in_valid = 1'b0; if5.in_data = '0;    if5.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) m_cnt[k] = 0;

    // reset held two cycles with a beat presented
    tick();
    tick();
    chk("rst out_valid", 32'(if3.out_valid), 0);
    chk("rst out_data",  32'(if3.out_data),  32'h00);
    chk("rst occupancy", 32'(if3.occupancy), 0);
    chk("rst in_ready",  32'(if3.in_ready),  1);
    rst = 1'b0;
    if3.in_valid = 1'b0;
    tick();

    // streaming 01..08 with downstream always ready
    if3.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if3.in_valid = (c < 8);
      if3.in_data  = 8'(c + 1);
      #1;
      chk("stream in_ready", 32'(if3.in_ready), 1);
      if (c >= 3 && c < 11) begin
        chk("stream out_valid", 32'(if3.out_valid), 1);
        chk("stream out_data",  32'(if3.out_data),  32'(c - 2));
      end else begin
        chk("stream out_valid idle", 32'(if3.out_valid), 0);
      end
      if (c >= 3 && c <= 8) chk("stream occupancy", 32'(if3.occupancy), 3);
      tick();
    end
    chk("stream drained occupancy", 32'(if3.occupancy), 0);

    // fill against a stalled output
    if3.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if3.in_valid = 1'b1;
      if3.in_data  = 8'(8'h10 + k);
      #1;
      chk("fill in_ready", 32'(if3.in_ready), 1);
      tick();
    end
    if3.in_data = 8'h13;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("full in_ready",  32'(if3.in_ready),  0);
      chk("full occupancy", 32'(if3.occupancy), 3);
      chk("full out_valid", 32'(if3.out_valid), 1);
      chk("full out_data",  32'(if3.out_data),  32'h10);
      tick();
    end

    // push and pop together while full
    if3.in_data   = 8'h20;
    if3.out_ready = 1'b1;
    #1;
    chk("pushpop in_ready", 32'(if3.in_ready), 1);
    chk("pushpop out_data", 32'(if3.out_data), 32'h10);
    tick();
    if3.in_valid = 1'b0;
    #1;
    chk("pushpop occupancy", 32'(if3.occupancy), 3);
    chk("pushpop next 11",   32'(if3.out_data),  32'h11);
    tick();
    chk("pushpop next 12",   32'(if3.out_data),  32'h12);
    chk("pushpop occ 2",     32'(if3.occupancy), 2);
    tick();
    chk("pushpop next 20",   32'(if3.out_data),  32'h20);
    chk("pushpop valid 20",  32'(if3.out_valid), 1);
    chk("pushpop occ 1",     32'(if3.occupancy), 1);
    tick();
    chk("pushpop empty",     32'(if3.out_valid), 0);
    chk("pushpop occ 0",     32'(if3.occupancy), 0);

    // flush with two beats held and a third presented
    if3.out_ready = 1'b0;
    if3.in_valid  = 1'b1;
    if3.in_data   = 8'h30;
    tick();
    if3.in_data = 8'h31;
    tick();
    chk("preflush occupancy", 32'(if3.occupancy), 2);
    flush = 1'b1;
    if3.in_data = 8'h32;
    tick();
    flush = 1'b0;
    if3.in_valid = 1'b0;
    #1;
    chk("flush out_valid", 32'(if3.out_valid), 0);
    chk("flush occupancy", 32'(if3.occupancy), 0);
    chk("flush out_data",  32'(if3.out_data),  32'h00);
    chk("flush in_ready",  32'(if3.in_ready),  1);
    if3.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("postflush out_valid", 32'(if3.out_valid), 0);
    end

    // random traffic, alternating light and heavy backpressure
    for (int c = 0; c < 1200; c++) begin
      for (int k = 0; k < 2; k++) begin
        r_iv[k] = ($urandom_range(0, 3) != 0);
        r_or[k] = ($urandom_range(0, 99) < ((((c / 150) % 2) == 0) ? 75 : 30));
        r_d[k]  = 16'($urandom);
      end
      if1.in_valid = r_iv[0]; if1.in_data = r_d[0]; if1.out_ready = r_or[0];
      if5.in_valid = r_iv[1]; if5.in_data = r_d[1]; if5.out_ready = r_or[1];
      #1;
      rnd_check(0, 1, if1.in_ready, if1.out_valid, if1.out_data, 32'(if1.occupancy));
      rnd_check(1, 5, if5.in_ready, if5.out_valid, if5.out_data, 32'(if5.occupancy));
      tick();
      model_step(0, 1);
      model_step(1, 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
